// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 5-stage core.
// Result-select codes, register index width and hazard FSM states.
package pipe_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] RESULT_MEM = 2'b01;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

endpackage

// File: rtl/hazard_mc_timer.sv
// Multi-cycle Decode occupancy timer.
// Counts a multi-cycle op down in BUSY; abort drops it without done.
module hazard_mc_timer
  import pipe_pkg::*;
#(
  parameter int unsigned MC_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic last,
  output logic done
);

  localparam logic [7:0] LAT_M1 = 8'(MC_LAT - 1);

  mc_state_t  state;
  mc_state_t  state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign busy = (state == MC_BUSY);
  assign last = busy && (cnt == 8'd1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    unique case (state)
      MC_IDLE: begin
        if (start) begin
          state_nxt = MC_BUSY;
          cnt_nxt   = LAT_M1;
        end
      end
      MC_BUSY: begin
        // A redirect means the op is wrong-path: no release pulse.
        if (abort) begin
          state_nxt = MC_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == 8'd1) begin
          state_nxt = MC_IDLE;
          cnt_nxt   = '0;
          done      = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = MC_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, redirect and multi-cycle stalls.
// Drives IF/ID and ID/EX stall/flush plus a stall-cycle counter.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdE,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              McOpD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              McBusy,
  output logic              McDoneD,
  output logic [CNT_W-1:0]  StallCount
);

  logic             lw_stall;
  logic             mc_go;
  logic             mc_stall;
  logic             stall;
  logic             busy;
  logic             last;
  logic             done;
  logic [CNT_W-1:0] stall_cnt;

  assign lw_stall = (ResultSrcE == RESULT_MEM)
                 && (RdE != '0)
                 && ((RdE == Rs1D) || (RdE == Rs2D));

  // Redirect and load-use both hold the op back from starting.
  assign mc_go = McOpD && !lw_stall && !PCSrcE;

  hazard_mc_timer #(
    .MC_LAT (MC_LAT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .start (mc_go),
    .abort (PCSrcE),
    .busy  (busy),
    .last  (last),
    .done  (done)
  );

  assign mc_stall = (!busy && mc_go)
                 || (busy && !last && !PCSrcE);

  assign stall = (lw_stall && !PCSrcE) || mc_stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    StallF     = 1'b0;
    StallD     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    McBusy     = 1'b0;
    McDoneD    = 1'b0;
    StallCount = '0;
    if (reset) begin
      StallF     = stall;
      StallD     = stall;
      FlushD     = PCSrcE;
      FlushE     = stall || PCSrcE;
      McBusy     = busy;
      McDoneD    = done;
      StallCount = stall_cnt;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MC_LAT=4, CNT_W=4).
// Drives after posedge, checks at negedge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, McOpD;
  logic       StallF, StallD, FlushD, FlushE, McBusy, McDoneD;
  logic [3:0] StallCount;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MC_LAT (4),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdE        (RdE),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .McOpD      (McOpD),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .McBusy     (McBusy),
    .McDoneD    (McDoneD),
    .StallCount (StallCount)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [1:0] rsrc,
                       input logic pc, input logic mc);
    Rs1D = rs1; Rs2D = rs2; RdE = rd;
    ResultSrcE = rsrc; PCSrcE = pc; McOpD = mc;
    @(negedge clk);
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    drive(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    idle();
    next();
    reset = 1'b1;
  endtask

  function automatic logic [5:0] outs();
    return {StallF, StallD, FlushD, FlushE, McBusy, McDoneD};
  endfunction

  logic [3:0] exp_stall = 4'b1110;
  logic [3:0] exp_done  = 4'b0001;
  logic [3:0] exp_busy  = 4'b0111;
  int         stalls;

  initial begin
    reset = 1'b0;
    // reset with a live hazard on the inputs: outputs forced low
    drive(5'd5, 5'd0, 5'd5, 2'b01, 1'b1, 1'b1);
    check("rst_outs", 32'(outs()), 32'h0);
    check("rst_cnt", 32'(StallCount), 32'd0);
    next();
    reset = 1'b1;
    idle();
    check("post_rst_outs", 32'(outs()), 32'h0);
    check("post_rst_cnt", 32'(StallCount), 32'd0);
    next();

    // load-use stall
    drive(5'd5, 5'd7, 5'd5, 2'b01, 1'b0, 1'b0);
    check("lu_outs", 32'(outs()), 32'b110100);
    check("lu_cnt0", 32'(StallCount), 32'd0);
    next();
    idle();
    check("lu_cnt1", 32'(StallCount), 32'd1);
    check("lu_clear", 32'(outs()), 32'h0);
    next();

    // x0 destination
    drive(5'd3, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0);
    check("x0_outs", 32'(outs()), 32'h0);
    next();
    // non-load producer is not a load-use
    drive(5'd9, 5'd4, 5'd9, 2'b00, 1'b0, 1'b0);
    check("alu_outs", 32'(outs()), 32'h0);
    next();

    // multi-cycle op
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b1);
      check($sformatf("mc_stall%0d", i), 32'(StallD), 32'(exp_stall[3-i]));
      check($sformatf("mc_done%0d", i), 32'(McDoneD), 32'(exp_done[3-i]));
      check($sformatf("mc_busy%0d", i), 32'(McBusy), 32'(exp_busy[3-i]));
      next();
    end
    idle();
    check("mc_cnt", 32'(StallCount), 32'd3);
    check("mc_idle", 32'(outs()), 32'h0);
    next();

    // back-to-back: new op detected right after release
    drive(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b1);
    check("b2b_detect", 32'(outs()), 32'b110100);
    next();
    idle();
    next();

    // branch abort mid-BUSY
    do_reset();
    drive(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b1);
    next();
    drive(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b1);
    next();
    drive(5'd1, 5'd2, 5'd3, 2'b00, 1'b1, 1'b1);
    check("br_outs", 32'(outs()), 32'b001110);
    next();
    idle();
    check("br_after", 32'(outs()), 32'h0);
    check("br_cnt", 32'(StallCount), 32'd2);
    next();

    // branch beats load-use
    drive(5'd5, 5'd0, 5'd5, 2'b01, 1'b1, 1'b0);
    check("br_lu_outs", 32'(outs()), 32'b001100);
    next();

    // load-use ahead of multi-cycle op
    do_reset();
    stalls = 0;
    drive(5'd5, 5'd2, 5'd5, 2'b01, 1'b0, 1'b1);
    check("lumc_c0", 32'(outs()), 32'b110100);
    stalls += int'(StallD);
    next();
    drive(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b1);
    check("lumc_c1", 32'(outs()), 32'b110100);
    stalls += int'(StallD);
    next();
    for (int i = 2; i < 5; i++) begin
      drive(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b1);
      check($sformatf("lumc_busy%0d", i), 32'(McBusy), 32'd1);
      stalls += int'(StallD);
      if (i == 4) check("lumc_done", 32'(McDoneD), 32'd1);
      next();
    end
    idle();
    stalls += int'(StallD);
    check("lumc_total", 32'(stalls), 32'd4);
    check("lumc_cnt", 32'(StallCount), 32'd4);
    next();

    // reset mid-BUSY
    do_reset();
    drive(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b1);
    next();
    drive(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b1);
    next();
    reset = 1'b0;
    drive(5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b1);
    check("mrst_outs", 32'(outs()), 32'h0);
    check("mrst_cnt", 32'(StallCount), 32'd0);
    next();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check($sformatf("mrst_idle%0d", i), 32'(outs()), 32'h0);
      check($sformatf("mrst_cnt%0d", i), 32'(StallCount), 32'd0);
      next();
    end

    // counter wrap at 4 bits
    for (int i = 0; i < 15; i++) begin
      drive(5'd6, 5'd6, 5'd6, 2'b01, 1'b0, 1'b0);
      next();
    end
    idle();
    check("wrap_15", 32'(StallCount), 32'd15);
    next();
    drive(5'd6, 5'd6, 5'd6, 2'b01, 1'b0, 1'b0);
    next();
    idle();
    check("wrap_0", 32'(StallCount), 32'd0);
    next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that produces the stall and flush controls consumed by the IF/ID and ID/EX registers. It detects load-use hazards and taken branches/jumps, and sequences a multi-cycle floating-point operation that must occupy Decode for `MC_LAT` cycles. It also keeps a saturating-free stall-cycle performance counter. It sits beside the hazard/forwarding logic in the 5-stage core. Its `FlushE` output drives the ID/EX flush input directly.

## Interface
- `MC_LAT`, default 4: cycles a multi-cycle FP op resides in Decode; legal range 2..255.
- `CNT_W`, default 32: width of the stall performance counter.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; `reset==0` at a rising edge clears all state.
- `Rs1D`, `Rs2D`  in  5 each  source registers of the instruction in Decode.
- `RdE`  in  5  destination register of the instruction in Execute.
- `ResultSrcE`  in  2  result select in Execute; `2'b01` marks a load.
- `PCSrcE`  in  1  taken branch or jump resolved in Execute.
- `McOpD`  in  1  instruction in Decode is a multi-cycle FP op.
- `StallF`, `StallD`  out  1 each  hold the PC and IF/ID.
- `FlushD`, `FlushE`  out  1 each  bubble IF/ID and ID/EX.
- `McBusy`  out  1  FSM is in BUSY.
- `McDoneD`  out  1  single-cycle pulse on the release cycle of a multi-cycle op.
- `StallCount`  out  `CNT_W`  number of cycles with `StallD==1` since reset.

## Operation
- Load-use detection: `lwStall = (ResultSrcE==2'b01) && (RdE!=0) && (RdE==Rs1D || RdE==Rs2D)`.
- FSM states:
  - IDLE: counter `cnt` = 0.
  - BUSY: `cnt` counts down.
- Transitions:
  - IDLE to BUSY when `McOpD && !lwStall && !PCSrcE`; on that edge `cnt <= MC_LAT-1`.
  - BUSY with `cnt!=1`: `cnt <= cnt-1`, stay in BUSY.
  - BUSY with `cnt==1`: release cycle. `McDoneD=1`, next state IDLE, `cnt <= 0`.
  - BUSY with `PCSrcE==1`: abort, because the op is wrong-path. Next state IDLE, `cnt <= 0`, and `McDoneD` stays 0.
- The multi-cycle stall condition `mcStall` is true in either of these cases:
  - state IDLE with the IDLE-to-BUSY condition true;
  - state BUSY with `cnt!=1` and `!PCSrcE`.
- Output equations (combinational from state and inputs):
  - `StallF = StallD = lwStall || mcStall`
  - `FlushE = lwStall || mcStall || PCSrcE`
  - `FlushD = PCSrcE`
  - If `PCSrcE` and `lwStall` are both 1, `PCSrcE` wins. Stalls are suppressed, `FlushD=FlushE=1`.
- Priority order: `PCSrcE` first, then `lwStall`, then multi-cycle. A `McOpD` held up by `lwStall` does not start the FSM until `lwStall` clears.
- `StallCount` increments by 1 on each edge where `StallD==1`. It wraps modulo 2^`CNT_W`.
- While `reset==0`, all outputs are forced to 0.

## Timing
- Reset values: state IDLE, `cnt=0`, `StallCount=0`. All outputs are 0 in the cycle after reset is sampled low.
- Load-use: exactly 1 stall cycle plus 1 ID/EX bubble per hazard.
- Multi-cycle op: resides in Decode for `MC_LAT` cycles.
  - `StallD` is high for `MC_LAT-1` cycles, starting from the detection cycle.
  - The last cycle is the release cycle: `StallD=0`, `McDoneD=1`.
  - `McBusy` is high for `MC_LAT-1` cycles, starting the cycle after detection.
- Back-to-back multi-cycle ops: the release cycle returns the FSM to IDLE. The next op is detected in the following cycle with no extra gap.
- Reset asserted mid-BUSY: the FSM returns to IDLE on that edge and no `McDoneD` is produced.
- `StallCount` wraps at all-ones. With `CNT_W=4`: 15 then 0.

## Structure
- Shared package `pipe_pkg` contains:
  - `RESULT_MEM = 2'b01`
  - the FSM state typedef (`MC_IDLE`, `MC_BUSY`)
  - the register-index width `REG_AW = 5`
- One sub-module, `hazard_mc_timer`. It holds the FSM and `cnt`, takes `start`, `abort` and `reset`, and outputs `busy`, `last` (`cnt==1`) and `done`.
- Load-use compare, output equations and `StallCount` live in the top module.

## Test plan
- Load-use stall: `ResultSrcE=01`, `RdE=5`, `Rs1D=5`, one cycle. Required: `StallF=StallD=FlushE=1`, `FlushD=0`, `StallCount` 0→1.
- x0 is never a hazard: `ResultSrcE=01`, `RdE=0`, `Rs2D=0`. Required: all outputs 0.
- Multi-cycle op, `MC_LAT=4`: `McOpD=1` held. Required:
  - `StallD` = 1,1,1,0;
  - `McDoneD` = 0,0,0,1;
  - `McBusy` = 0,1,1,1;
  - `StallCount`=3 afterwards.
- Branch abort: taken branch arrives mid-BUSY. Required:
  - `McOpD=1` and `MC_LAT=4`; cycle 2 has `PCSrcE=1`.
  - In cycle 2, `FlushD=FlushE=1` and `StallD=0`.
  - FSM returns to IDLE with no `McDoneD`.
- Load-use ahead of a multi-cycle op: `lwStall` and `McOpD` in the same cycle. Required:
  - 1 load-use stall cycle first.
  - FSM enters BUSY only in the following cycle.
  - Total `StallD` cycles = 1 + (`MC_LAT`-1).
- Reset mid-BUSY, then wrap: `reset=0` at cycle 2 of BUSY. Required:
  - Outputs 0, state IDLE, `StallCount=0`.
  - With `CNT_W=4`, after 16 stall cycles `StallCount` reads 0.
